hpi_access_sequencer: RTL and testbench
=======================================

Name: hpi_access_sequencer

Overview:
- Two-port arbiter and bus sequencer in front of the registered HPI I/O interface to the on-board USB host controller.
- Accepts 16-bit read/write requests from two requesters: port 0 is the software/bus-bridge path, port 1 is the hardware USB poller.
- Grants one request at a time, round-robin.
- Drives the interface's address, data, active-low read, write and chip-select inputs with programmable setup, strobe, hold and recovery timing.
- Returns read data and a one-cycle ack to the granted requester.

Parameters:
- STROBE_CYCLES, 2, cycles the read or write strobe is held low; legal range 1..15.
- HOLD_CYCLES, 2, cycles CS stays low after the strobe rises; legal range 2..15 (the minimum of 2 covers the interface's output and input register stages).
- RECOVER_CYCLES, 2, cycles CS is held high before the next access; legal range 1..15.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- req0  in  1  port 0 request; held high until ack0
- we0  in  1  port 0 operation; 1 = write, 0 = read
- addr0  in  2  port 0 HPI register address
- wdata0  in  16  port 0 write data
- ack0  out  1  port 0 completion pulse, one cycle
- rdata0  out  16  port 0 read data; valid while ack0 is high, then held
- req1, we1, addr1, wdata1, ack1, rdata1  same widths and meaning, port 1
- hpi_address  out  2  to the interface address input
- hpi_data_out  out  16  to the interface write-data input
- hpi_r  out  1  to the interface read strobe, active low
- hpi_w  out  1  to the interface write strobe, active low
- hpi_cs  out  1  to the interface chip select, active low
- hpi_data_in  in  16  registered read data from the interface
- busy  out  1  high in every state except IDLE
- grant_id  out  1  port owning the current or most recent access

Behaviour:
- Reset (asynchronous, immediate, including mid-access):
  - state = IDLE.
  - hpi_r = hpi_w = hpi_cs = 1.
  - hpi_address = 0, hpi_data_out = 0.
  - ack0 = ack1 = 0, rdata0 = rdata1 = 0.
  - busy = 0, grant_id = 0, round-robin pointer last = 1 (port 0 wins the first tie).
- States: IDLE, SETUP, STROBE, HOLD, RECOVER. One 4-bit down-counter times STROBE, HOLD and RECOVER.
- IDLE:
  - Only req0 high: grant port 0. Only req1 high: grant port 1.
  - Both high: grant the port not equal to last; then last = granted port.
  - On grant, latch we, addr and wdata into internal registers, drive grant_id, go to SETUP.
  - hpi_address and hpi_data_out follow the latched values from SETUP onward and hold them until the next grant.
- SETUP (1 cycle): hpi_cs = 0, strobes high. Next state STROBE, counter = STROBE_CYCLES-1.
- STROBE:
  - hpi_cs = 0.
  - Write: hpi_w = 0. Read: hpi_r = 0.
  - At counter 0, go to HOLD with counter = HOLD_CYCLES-1.
- HOLD:
  - hpi_cs = 0, strobes high.
  - Read: the granted rdata register captures hpi_data_in at the clock edge ending the second HOLD cycle. This reflects the last pin cycle of the strobe, after the interface's two register stages.
  - At counter 0, go to RECOVER with counter = RECOVER_CYCLES-1.
- RECOVER:
  - hpi_cs = 1.
  - The granted ack is high in the first RECOVER cycle only, for both read and write.
  - At counter 0, go to IDLE.
- The non-granted port's ack and rdata are never touched.
- Requester rules:
  - Drop req at the edge ending the ack cycle, or issue a new request by keeping req high.
  - A req sampled high in IDLE after its ack is treated as a new request.
  - Dropping req before ack does not abort the access; the access completes and ack still pulses.
  - Request inputs are not re-sampled while busy.
- Total access time = 1 + STROBE_CYCLES + HOLD_CYCLES + RECOVER_CYCLES cycles after the grant cycle, plus 1 IDLE cycle between accesses.
- hpi_r and hpi_w are never low in the same cycle.
- Neither strobe is low while hpi_cs = 1.
- Reset asserted during STROBE: strobes return high at once. No ack is issued and the access is lost.

Test Plan:
- Reset check: assert Reset mid-STROBE of a write -> hpi_w, hpi_cs and hpi_r high in the same cycle; busy = 0; no ack0 after release.
- Single write, default parameters: req0 = 1, we0 = 1, addr0 = 2'b10, wdata0 = 16'hBEEF in IDLE at cycle 0 -> required sequence:
  - cycle 1: SETUP with hpi_cs = 0.
  - cycles 2-3: hpi_w = 0.
  - cycles 4-5: HOLD.
  - cycle 6: ack0 = 1.
  - cycle 8: IDLE.
  - hpi_address = 2 and hpi_data_out = BEEF throughout.
- Single read: req1 = 1, we1 = 0, addr1 = 2'b01; bench drives hpi_data_in = 16'h1234 during the second HOLD cycle -> ack1 in the first RECOVER cycle with rdata1 = 1234; hpi_w stays high; rdata0 unchanged.
- Contention: req0 and req1 high together, held high through repeated accesses -> grants alternate 0,1,0,1; each access is separated by RECOVER_CYCLES + 1 IDLE cycle; grant_id matches.
- Early request drop: req0 dropped during STROBE -> access completes and ack0 still pulses once.
- Parameter sweep: STROBE_CYCLES = 1, HOLD_CYCLES = 2, RECOVER_CYCLES = 1 -> read still returns correct data; total access time is 5 cycles after the grant cycle.

Source files
------------

// File: rtl/hpi_access_sequencer_if.sv
// hpi_access_sequencer_if: requester handshakes and HPI pin bundle for the access sequencer.
// The sequencer takes the slave view; requesters and the HPI side take the master view.
interface hpi_access_sequencer_if;
    logic        req0, we0, ack0;
    logic [1:0]  addr0;
    logic [15:0] wdata0, rdata0;
    logic        req1, we1, ack1;
    logic [1:0]  addr1;
    logic [15:0] wdata1, rdata1;
    logic [1:0]  hpi_address;
    logic [15:0] hpi_data_out, hpi_data_in;
    logic        hpi_r, hpi_w, hpi_cs;
    logic        busy, grant_id;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, hpi_data_in,
        output ack0, rdata0, ack1, rdata1, hpi_address, hpi_data_out,
        output hpi_r, hpi_w, hpi_cs, busy, grant_id
    );
    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, hpi_data_in,
        input  ack0, rdata0, ack1, rdata1, hpi_address, hpi_data_out,
        input  hpi_r, hpi_w, hpi_cs, busy, grant_id
    );
endinterface

// File: rtl/hpi_access_sequencer.sv
// hpi_access_sequencer: round-robin two-port arbiter driving timed HPI read/write cycles.
// One down-counter times the strobe, hold and recovery phases of each access.
module hpi_access_sequencer #(
    parameter int STROBE_CYCLES  = 2,
    parameter int HOLD_CYCLES    = 2,
    parameter int RECOVER_CYCLES = 2
) (
    input logic Clk,
    input logic Reset,
    hpi_access_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

    localparam logic [3:0] STB_N  = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_N = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] HOLD_2 = 4'(HOLD_CYCLES - 2);
    localparam logic [3:0] REC_N  = 4'(RECOVER_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d, grant_q, grant_d, last_q, last_d, g;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        ack;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        grant_d  = grant_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        g        = (bus.req0 && bus.req1) ? !last_q : bus.req1;
        case (state_q)
            IDLE: if (bus.req0 || bus.req1) begin
                grant_d = g;
                last_d  = g;
                we_d    = g ? bus.we1 : bus.we0;
                addr_d  = g ? bus.addr1 : bus.addr0;
                wdata_d = g ? bus.wdata1 : bus.wdata0;
                state_d = SETUP;
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = STB_N;
            end
            STROBE: begin
                state_d = (cnt_q == 4'd0) ? HOLD : STROBE;
                cnt_d   = (cnt_q == 4'd0) ? HOLD_N : cnt_q - 4'd1;
            end
            HOLD: begin
                // Second hold cycle: the last strobe cycle has cleared both interface register stages.
                if (!we_q && cnt_q == HOLD_2) begin
                    rdata0_d = grant_q ? rdata0_q : bus.hpi_data_in;
                    rdata1_d = grant_q ? bus.hpi_data_in : rdata1_q;
                end
                state_d = (cnt_q == 4'd0) ? RECOVER : HOLD;
                cnt_d   = (cnt_q == 4'd0) ? REC_N : cnt_q - 4'd1;
            end
            RECOVER: begin
                state_d = (cnt_q == 4'd0) ? IDLE : RECOVER;
                cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ack              = (state_q == RECOVER) && (cnt_q == REC_N);
    assign bus.ack0         = ack && !grant_q;
    assign bus.ack1         = ack && grant_q;
    assign bus.rdata0       = rdata0_q;
    assign bus.rdata1       = rdata1_q;
    assign bus.hpi_address  = addr_q;
    assign bus.hpi_data_out = wdata_q;
    assign bus.hpi_cs       = !(state_q == SETUP || state_q == STROBE || state_q == HOLD);
    assign bus.hpi_w        = !(state_q == STROBE && we_q);
    assign bus.hpi_r        = !(state_q == STROBE && !we_q);
    assign bus.busy         = state_q != IDLE;
    assign bus.grant_id     = grant_q;
endmodule

// File: tb/tb_hpi_access_sequencer.sv
// tb_hpi_access_sequencer: directed checks of arbitration, pin timing, read capture and reset.
module tb_hpi_access_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   acks;

    hpi_access_sequencer_if b ();
    hpi_access_sequencer_if s ();

    hpi_access_sequencer dut (.Clk(clk), .Reset(rst), .bus(b.slave));
    hpi_access_sequencer #(.STROBE_CYCLES(1), .HOLD_CYCLES(2), .RECOVER_CYCLES(1))
        dut_s (.Clk(clk), .Reset(rst), .bus(s.slave));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        {b.req0, b.we0, b.addr0, b.wdata0, b.req1, b.we1, b.addr1, b.wdata1} = '0;
        {s.req0, s.we0, s.addr0, s.wdata0, s.req1, s.we1, s.addr1, s.wdata1} = '0;
        b.hpi_data_in = 16'h5555;
        s.hpi_data_in = 16'h0000;
        repeat (3) tick;
        rst = 1'b0;
        tick;

        chk("rst_r", 16'(b.hpi_r), 16'd1);
        chk("rst_w", 16'(b.hpi_w), 16'd1);
        chk("rst_cs", 16'(b.hpi_cs), 16'd1);
        chk("rst_busy", 16'(b.busy), 16'd0);
        chk("rst_grant", 16'(b.grant_id), 16'd0);
        chk("rst_acks", 16'({b.ack0, b.ack1}), 16'd0);
        chk("rst_rdata0", b.rdata0, 16'd0);
        chk("rst_rdata1", b.rdata1, 16'd0);
        chk("rst_addr", 16'(b.hpi_address), 16'd0);
        chk("rst_dout", b.hpi_data_out, 16'd0);

        b.req0 = 1'b1; b.we0 = 1'b1; b.addr0 = 2'b10; b.wdata0 = 16'hBEEF;
        for (int c = 1; c <= 8; c++) begin
            tick;
            chk("wr_cs", 16'(b.hpi_cs), 16'(c > 5));
            chk("wr_w", 16'(b.hpi_w), 16'(!(c == 2 || c == 3)));
            chk("wr_r", 16'(b.hpi_r), 16'd1);
            chk("wr_ack0", 16'(b.ack0), 16'(c == 6));
            chk("wr_busy", 16'(b.busy), 16'(c <= 7));
            chk("wr_addr", 16'(b.hpi_address), 16'd2);
            chk("wr_dout", b.hpi_data_out, 16'hBEEF);
            if (c == 6) b.req0 = 1'b0;
        end

        b.req1 = 1'b1; b.we1 = 1'b0; b.addr1 = 2'b01;
        for (int c = 1; c <= 8; c++) begin
            tick;
            b.hpi_data_in = (c == 5) ? 16'h1234 : 16'h5555;
            chk("rd_w", 16'(b.hpi_w), 16'd1);
            chk("rd_r", 16'(b.hpi_r), 16'(!(c == 2 || c == 3)));
            chk("rd_ack1", 16'(b.ack1), 16'(c == 6));
            chk("rd_ack0", 16'(b.ack0), 16'd0);
            chk("rd_grant", 16'(b.grant_id), 16'd1);
            chk("rd_rdata0", b.rdata0, 16'd0);
            if (c == 1) chk("rd_addr", 16'(b.hpi_address), 16'd1);
            if (c == 6 || c == 7) chk("rd_rdata1", b.rdata1, 16'h1234);
            if (c == 6) b.req1 = 1'b0;
        end

        b.req0 = 1'b1; b.we0 = 1'b0; b.addr0 = 2'b11;
        for (int c = 1; c <= 10; c++) begin
            tick;
            b.hpi_data_in = (c == 5) ? 16'hABCD : 16'h5555;
            if (c == 2) b.req0 = 1'b0;
            chk("drop_ack0", 16'(b.ack0), 16'(c == 6));
            chk("drop_busy", 16'(b.busy), 16'(c <= 7));
            if (c == 6) chk("drop_rdata0", b.rdata0, 16'hABCD);
            if (c == 6) chk("drop_rdata1", b.rdata1, 16'h1234);
        end

        b.req0 = 1'b1; b.we0 = 1'b1; b.addr0 = 2'b01; b.wdata0 = 16'h5A5A;
        tick;
        tick;
        chk("rst_mid_w_low", 16'(b.hpi_w), 16'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid_w", 16'(b.hpi_w), 16'd1);
        chk("rst_mid_r", 16'(b.hpi_r), 16'd1);
        chk("rst_mid_cs", 16'(b.hpi_cs), 16'd1);
        chk("rst_mid_busy", 16'(b.busy), 16'd0);
        b.req0 = 1'b0;
        tick;
        rst = 1'b0;
        acks = 0;
        repeat (10) begin
            tick;
            if (b.ack0) acks++;
        end
        chk("rst_mid_noack", 16'(acks), 16'd0);
        chk("rst_mid_idle", 16'(b.busy), 16'd0);

        b.req0 = 1'b1; b.we0 = 1'b1; b.addr0 = 2'b00; b.wdata0 = 16'h1111;
        b.req1 = 1'b1; b.we1 = 1'b1; b.addr1 = 2'b11; b.wdata1 = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            for (int c = 1; c <= 8; c++) begin
                tick;
                if (c == 1) begin
                    chk("rr_grant", 16'(b.grant_id), 16'(k % 2));
                    chk("rr_addr", 16'(b.hpi_address), (k % 2 == 1) ? 16'd3 : 16'd0);
                    chk("rr_dout", b.hpi_data_out, (k % 2 == 1) ? 16'h2222 : 16'h1111);
                end
                if (c == 6) begin
                    chk("rr_ack0", 16'(b.ack0), 16'(k % 2 == 0));
                    chk("rr_ack1", 16'(b.ack1), 16'(k % 2 == 1));
                end
                if (c == 8) chk("rr_idle", 16'(b.busy), 16'd0);
            end
        end
        b.req0 = 1'b0;
        b.req1 = 1'b0;

        s.req0 = 1'b1; s.we0 = 1'b0; s.addr0 = 2'b10;
        for (int c = 1; c <= 6; c++) begin
            tick;
            s.hpi_data_in = (c == 4) ? 16'h0F0F : 16'h0000;
            chk("sw_r", 16'(s.hpi_r), 16'(c != 2));
            chk("sw_w", 16'(s.hpi_w), 16'd1);
            chk("sw_cs", 16'(s.hpi_cs), 16'(c > 4));
            chk("sw_ack0", 16'(s.ack0), 16'(c == 5));
            chk("sw_busy", 16'(s.busy), 16'(c <= 5));
            if (c == 5) begin
                chk("sw_rdata0", s.rdata0, 16'h0F0F);
                s.req0 = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
